slc3_button_conditioner: RTL and testbench

//  Front-end conditioner for the SLC-3 board inputs; sits directly upstream of slc3_testtop.

---
 rtl/slc3_button_conditioner.sv | 149 ++++++++++++++
 tb/tb_slc3_button_conditioner.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/slc3_button_conditioner.sv
// Debounces the SLC-3 Run/Continue keys into single-cycle pulses and
// synchronizes the switch bank, latching a stable copy on every accepted press.
module slc3_button_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned SW_WIDTH        = 10
) (
  input  logic                Clk,
  input  logic                Reset_n,
  input  logic                Run_n,
  input  logic                Continue_n,
  input  logic [SW_WIDTH-1:0] SW,
  output logic                Run_pulse,
  output logic                Continue_pulse,
  output logic                Run_level,
  output logic                Continue_level,
  output logic [SW_WIDTH-1:0] SW_sync,
  output logic [SW_WIDTH-1:0] SW_latched
);

  localparam int unsigned NKEYS = 2;
  localparam int unsigned CW    = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    PRESS_WAIT,
    HELD,
    RELEASE_WAIT
  } key_state_e;

  logic [NKEYS-1:0]    key_raw;
  logic [NKEYS-1:0]    key_meta;
  logic [NKEYS-1:0]    key_sync_n;
  logic [NKEYS-1:0]    key_pressed;
  logic [NKEYS-1:0]    key_pulse_d;
  logic [NKEYS-1:0]    key_pulse_q;
  logic [NKEYS-1:0]    key_level_q;
  logic [SW_WIDTH-1:0] sw_meta;

  assign key_raw     = {Continue_n, Run_n};
  assign key_pressed = ~key_sync_n;

  // Two-flop synchronizers; keys reset to the released (high) level.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      key_meta   <= '1;
      key_sync_n <= '1;
      sw_meta    <= '0;
      SW_sync    <= '0;
    end else begin
      key_meta   <= key_raw;
      key_sync_n <= key_meta;
      sw_meta    <= SW;
      SW_sync    <= sw_meta;
    end
  end

  for (genvar k = 0; k < NKEYS; k++) begin : g_key
    key_state_e    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          level_q, level_d;
    logic          pulse_q, pulse_d;

    always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
        state_q <= IDLE;
        cnt_q   <= '0;
        level_q <= 1'b0;
        pulse_q <= 1'b0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        level_q <= level_d;
        pulse_q <= pulse_d;
      end
    end

    // Debounce FSM: a level change needs DEBOUNCE_CYCLES stable samples past entry.
    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      level_d = level_q;
      pulse_d = 1'b0;
      case (state_q)
        IDLE: begin
          if (key_pressed[k]) begin
            state_d = PRESS_WAIT;
            cnt_d   = '0;
          end
        end
        PRESS_WAIT: begin
          if (!key_pressed[k]) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else if (cnt_q == CNT_LAST) begin
            state_d = HELD;
            cnt_d   = '0;
            level_d = 1'b1;
            pulse_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        HELD: begin
          if (!key_pressed[k]) begin
            state_d = RELEASE_WAIT;
            cnt_d   = '0;
          end
        end
        RELEASE_WAIT: begin
          if (key_pressed[k]) begin
            state_d = HELD;
            cnt_d   = '0;
          end else if (cnt_q == CNT_LAST) begin
            state_d = IDLE;
            cnt_d   = '0;
            level_d = 1'b0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
          level_d = 1'b0;
        end
      endcase
    end

    assign key_pulse_d[k] = pulse_d;
    assign key_pulse_q[k] = pulse_q;
    assign key_level_q[k] = level_q;
  end

  // Capture the switches once per accepted press, even if both keys fire together.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      SW_latched <= '0;
    end else if (|key_pulse_d) begin
      SW_latched <= SW_sync;
    end
  end

  assign Run_pulse      = key_pulse_q[0];
  assign Continue_pulse = key_pulse_q[1];
  assign Run_level      = key_level_q[0];
  assign Continue_level = key_level_q[1];

endmodule

// File: tb/tb_slc3_button_conditioner.sv
// Scoreboard bench for slc3_button_conditioner: a run-length debounce model
// predicts every cycle's outputs and every pulse event; monitors compare.
module tb_slc3_button_conditioner;

  localparam int unsigned D = 4;
  localparam int unsigned W = 10;

  logic         Clk = 1'b0;
  logic         Reset_n, Run_n, Continue_n;
  logic [W-1:0] SW;
  logic         Run_pulse, Continue_pulse, Run_level, Continue_level;
  logic [W-1:0] SW_sync, SW_latched;

  always #5 Clk = ~Clk;

  slc3_button_conditioner #(.DEBOUNCE_CYCLES(D), .SW_WIDTH(W)) dut (
    .Clk           (Clk),
    .Reset_n       (Reset_n),
    .Run_n         (Run_n),
    .Continue_n    (Continue_n),
    .SW            (SW),
    .Run_pulse     (Run_pulse),
    .Continue_pulse(Continue_pulse),
    .Run_level     (Run_level),
    .Continue_level(Continue_level),
    .SW_sync       (SW_sync),
    .SW_latched    (SW_latched)
  );

  typedef struct packed {logic rn; logic cn; logic [W-1:0] sw;} samp_t;
  typedef struct packed {logic rp; logic cp; logic rl; logic cl; logic [W-1:0] sws; logic [W-1:0] swl;} exp_t;
  typedef struct packed {logic rp; logic cp; logic [W-1:0] swl;} evt_t;

  samp_t hist[$];
  exp_t  exp_q[$];
  evt_t  evt_q[$];

  int unsigned vectors = 0, miscompares = 0;
  int unsigned run_seen = 0, cont_seen = 0;

  // Reference model: outputs seen after edge e depend on inputs sampled two edges earlier;
  // a level flips once the opposite value has been seen D+1 edges in a row.
  bit           m_level [2];
  int unsigned  m_run   [2];
  logic [W-1:0] m_latched;

  always @(posedge Clk) begin
    samp_t s, v1, v2;
    exp_t  e;
    evt_t  ev;
    bit    view [2];
    bit    pulse [2];
    if (!Reset_n) begin
      hist.delete();
      for (int k = 0; k < 2; k++) begin m_level[k] = 1'b0; m_run[k] = 0; end
      m_latched = '0;
      e = '0;
      exp_q.push_back(e);
    end else begin
      s = '{rn: Run_n, cn: Continue_n, sw: SW};
      hist.push_back(s);
      if (hist.size() > 3) void'(hist.pop_front());
      v1 = '{rn: 1'b1, cn: 1'b1, sw: '0};
      v2 = v1;
      if (hist.size() >= 2) v1 = hist[hist.size()-2];
      if (hist.size() >= 3) v2 = hist[hist.size()-3];
      view[0] = !v2.rn;
      view[1] = !v2.cn;
      for (int k = 0; k < 2; k++) begin
        pulse[k] = 1'b0;
        if (view[k] != m_level[k]) m_run[k]++;
        else m_run[k] = 0;
        if (m_run[k] == D + 1) begin
          m_level[k] = view[k];
          m_run[k]   = 0;
          pulse[k]   = view[k];
        end
      end
      if (pulse[0] || pulse[1]) begin
        m_latched = v2.sw;
        ev = '{rp: pulse[0], cp: pulse[1], swl: m_latched};
        evt_q.push_back(ev);
      end
      e = '{rp: pulse[0], cp: pulse[1], rl: m_level[0], cl: m_level[1], sws: v1.sw, swl: m_latched};
      exp_q.push_back(e);
    end
  end

  // Per-cycle monitor plus pulse-event scoreboard.
  always @(posedge Clk) begin
    exp_t e;
    evt_t ev;
    #1;
    vectors++;
    if (exp_q.size() == 0) begin
      miscompares++;
      $display("FAIL cycle_exp: no expected entry at t=%0t", $time);
    end else begin
      e = exp_q.pop_front();
      if ({Run_pulse, Continue_pulse, Run_level, Continue_level, SW_sync, SW_latched} !==
          {e.rp, e.cp, e.rl, e.cl, e.sws, e.swl}) begin
        miscompares++;
        $display("FAIL cycle t=%0t: got rp=%b cp=%b rl=%b cl=%b sws=%h swl=%h, want rp=%b cp=%b rl=%b cl=%b sws=%h swl=%h",
                 $time, Run_pulse, Continue_pulse, Run_level, Continue_level, SW_sync, SW_latched,
                 e.rp, e.cp, e.rl, e.cl, e.sws, e.swl);
      end
    end
    if (Run_pulse === 1'b1) run_seen++;
    if (Continue_pulse === 1'b1) cont_seen++;
    if (Run_pulse === 1'b1 || Continue_pulse === 1'b1) begin
      vectors++;
      if (evt_q.size() == 0) begin
        miscompares++;
        $display("FAIL pulse_event t=%0t: unexpected pulse rp=%b cp=%b", $time, Run_pulse, Continue_pulse);
      end else begin
        ev = evt_q.pop_front();
        if ({Run_pulse, Continue_pulse, SW_latched} !== {ev.rp, ev.cp, ev.swl}) begin
          miscompares++;
          $display("FAIL pulse_event t=%0t: got rp=%b cp=%b swl=%h, want rp=%b cp=%b swl=%h",
                   $time, Run_pulse, Continue_pulse, SW_latched, ev.rp, ev.cp, ev.swl);
        end
      end
    end
  end

  task automatic step(input int unsigned n);
    repeat (n) @(negedge Clk);
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %0h, want %0h", name, got, want);
    end
  endtask

  int unsigned r0, c0;
  int unsigned seg_left [2];
  logic        seg_val  [2];

  initial begin
    Reset_n = 1'b1; Run_n = 1'b1; Continue_n = 1'b1; SW = '0;
    #2 Reset_n = 1'b0;
    step(3);
    check("reset_outputs", 32'({Run_pulse, Continue_pulse, Run_level, Continue_level, SW_sync, SW_latched}), 32'd0);
    Reset_n = 1'b1;
    step(2);

    // Clean press
    r0 = run_seen;
    Run_n = 1'b0; step(20);
    check("clean_level_held", 32'(Run_level), 32'd1);
    Run_n = 1'b1; step(12);
    check("clean_pulse_count", run_seen - r0, 32'd1);
    check("clean_level_released", 32'(Run_level), 32'd0);

    // Press bounce rejected
    r0 = run_seen;
    Run_n = 1'b0; step(2); Run_n = 1'b1; step(1);
    Run_n = 1'b0; step(2); Run_n = 1'b1; step(10);
    check("bounce_pulse_count", run_seen - r0, 32'd0);
    check("bounce_level", 32'(Run_level), 32'd0);

    // Switch latch across two Continue presses
    c0 = cont_seen;
    SW = 10'h031; step(3);
    Continue_n = 1'b0; step(10);
    SW = 10'h002; step(10);
    check("latch_first", 32'(SW_latched), 32'h031);
    Continue_n = 1'b1; step(12);
    check("latch_hold", 32'(SW_latched), 32'h031);
    Continue_n = 1'b0; step(10);
    Continue_n = 1'b1; step(12);
    check("latch_second", 32'(SW_latched), 32'h002);
    check("latch_pulse_count", cont_seen - c0, 32'd2);

    // Simultaneous acceptance
    r0 = run_seen; c0 = cont_seen;
    SW = 10'h3aa; step(3);
    Run_n = 1'b0; Continue_n = 1'b0; step(10);
    Run_n = 1'b1; Continue_n = 1'b1; step(12);
    check("simul_run_count", run_seen - r0, 32'd1);
    check("simul_cont_count", cont_seen - c0, 32'd1);
    check("simul_latch", 32'(SW_latched), 32'h3aa);

    // Release glitch while held
    r0 = run_seen;
    Run_n = 1'b0; step(10);
    Run_n = 1'b1; step(2);
    Run_n = 1'b0; step(10);
    check("glitch_level", 32'(Run_level), 32'd1);
    Run_n = 1'b1; step(12);
    check("glitch_pulse_count", run_seen - r0, 32'd1);

    // Reset in the middle of the press debounce
    Run_n = 1'b0; step(5);
    Reset_n = 1'b0; #1;
    check("reset_async", 32'({Run_pulse, Continue_pulse, Run_level, Continue_level, SW_sync, SW_latched}), 32'd0);
    step(2);
    r0 = run_seen;
    Reset_n = 1'b1; step(10);
    check("reset_repress_count", run_seen - r0, 32'd1);
    Run_n = 1'b1; step(12);

    // Randomized bouncy keys, switch churn and occasional resets
    for (int k = 0; k < 2; k++) begin seg_left[k] = 0; seg_val[k] = 1'b1; end
    for (int i = 0; i < 2000; i++) begin
      for (int k = 0; k < 2; k++) begin
        if (seg_left[k] == 0) begin
          seg_val[k]  = 1'($urandom_range(0, 1));
          seg_left[k] = ($urandom_range(0, 1) == 0) ? $urandom_range(1, 3) : $urandom_range(4, 14);
        end
        seg_left[k]--;
      end
      Run_n      = seg_val[0];
      Continue_n = seg_val[1];
      if ($urandom_range(0, 7) == 0) SW = W'($urandom);
      Reset_n = ($urandom_range(0, 299) == 0) ? 1'b0 : 1'b1;
      step(1);
    end
    Reset_n = 1'b1; Run_n = 1'b1; Continue_n = 1'b1;
    step(15);
    check("events_drained", evt_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
